// File: rtl/tile_reader_2x.sv
// -----------------------------------------------------------------------------
// tile_reader_2x
//   Raster-order tile fetcher feeding the conv datapath two elements per beat.
//   Walks a cfg_tile_h x cfg_tile_w window of an img_h x img_w single-channel,
//   row-major feature map at cfg_base_addr. Positions outside the image (the
//   conv halo) are not read; cfg_pad_value is substituted instead. Read data
//   returns RD_LAT cycles after the request and is captured into a skid FIFO
//   of RD_LAT+2 beats. A pair is only issued when the FIFO plus the read
//   pipeline has room for it, so no beat is lost under backpressure.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start                         one-cycle pulse, latches cfg_* when idle
//   cfg_img_h/w, cfg_base_addr    image geometry and base address
//   cfg_tile_row/col              signed tile origin (may be negative)
//   cfg_tile_h/w                  tile size (0 in either -> empty tile)
//   cfg_pad_value                 value emitted for out-of-image positions
//   rd_en0/1, rd_addr0/1          memory read requests, lane 0 / lane 1
//   rd_data0/1                    read data, RD_LAT cycles after request
//   out_valid/out_ready           output beat handshake
//   out_two, out_data0/1          beat payload (element k, element k+1)
//   busy, done                    operation in progress / completion pulse
// -----------------------------------------------------------------------------
module tile_reader_2x #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [DIM_W-1:0]  cfg_tile_row,
  input  logic [DIM_W-1:0]  cfg_tile_col,
  input  logic [DIM_W-1:0]  cfg_tile_h,
  input  logic [DIM_W-1:0]  cfg_tile_w,
  input  logic [DATA_W-1:0] cfg_pad_value,
  output logic              rd_en0,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic              rd_en1,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_two,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int N_W   = 2 * DIM_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DIM_W-1:0] r;
    logic [DIM_W-1:0] c;
  } pos_t;

  typedef struct packed {
    logic              inb;
    logic [ADDR_W-1:0] addr;
  } lane_t;

  // One read-pipeline slot: what the capture stage needs to know about a pair.
  typedef struct packed {
    logic vld;
    logic two;
    logic pad0;
    logic pad1;
  } stage_t;

  typedef struct packed {
    logic              two;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } beat_t;

  state_t state_q, state_d;

  // Latched configuration.
  logic [DIM_W-1:0]  img_h_q, img_w_q, row_q, col_q, tile_w_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] pad_q;

  // Raster walk: current position and elements still to issue.
  pos_t           pos_q;
  logic [N_W-1:0] remain_q;

  stage_t pipe_q [RD_LAT];

  beat_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Next raster position inside the tile, wrapping the column at tile_w-1.
  function automatic pos_t next_pos(pos_t p, logic [DIM_W-1:0] w);
    pos_t n;
    if (p.c == w - DIM_W'(1)) begin
      n.r = p.r + DIM_W'(1);
      n.c = '0;
    end else begin
      n.r = p.r;
      n.c = p.c + DIM_W'(1);
    end
    return n;
  endfunction

  // Image coordinates are formed one bit wider than DIM_W so that a negative
  // origin plus a tile offset is represented exactly before the bounds test.
  function automatic lane_t map_lane(pos_t p);
    logic signed [DIM_W:0] ir, ic;
    logic [N_W-1:0]        prod;
    lane_t                 l;
    ir    = $signed({row_q[DIM_W-1], row_q}) + $signed({1'b0, p.r});
    ic    = $signed({col_q[DIM_W-1], col_q}) + $signed({1'b0, p.c});
    l.inb = !ir[DIM_W] && (ir[DIM_W-1:0] < img_h_q) &&
            !ic[DIM_W] && (ic[DIM_W-1:0] < img_w_q);
    prod  = {{DIM_W{1'b0}}, ir[DIM_W-1:0]} * {{DIM_W{1'b0}}, img_w_q};
    l.addr = l.inb ? (base_q + ADDR_W'(prod) + ADDR_W'(ic[DIM_W-1:0])) : '0;
    return l;
  endfunction

  pos_t   pos1, pos2;
  lane_t  lane0, lane1;
  logic   two, issue, push, pop;
  int     inflight;
  beat_t  push_beat, head;

  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves a variable unassigned and a latch is never inferred.
  always_comb begin
    pos1     = next_pos(pos_q, tile_w_q);
    pos2     = next_pos(pos1, tile_w_q);
    lane0    = map_lane(pos_q);
    lane1    = map_lane(pos1);
    two      = (remain_q > N_W'(1));

    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(pipe_q[i].vld);

    // Credit rule: FIFO entries plus pairs still in the read pipeline.
    issue    = (state_q == S_ISSUE) && ((int'(count_q) + inflight) < DEPTH);

    rd_en0   = issue && lane0.inb;
    rd_addr0 = issue ? lane0.addr : '0;
    rd_en1   = issue && two && lane1.inb;
    rd_addr1 = (issue && two) ? lane1.addr : '0;

    push         = pipe_q[RD_LAT-1].vld;
    push_beat.two = pipe_q[RD_LAT-1].two;
    push_beat.d0  = pipe_q[RD_LAT-1].pad0 ? pad_q : rd_data0;
    push_beat.d1  = !pipe_q[RD_LAT-1].two ? '0 :
                    (pipe_q[RD_LAT-1].pad1 ? pad_q : rd_data1);

    head      = fifo_mem[rd_ptr_q];
    out_valid = (count_q != '0);
    out_two   = out_valid && head.two;
    out_data0 = out_valid ? head.d0 : '0;
    out_data1 = out_valid ? head.d1 : '0;
    pop       = out_valid && out_ready;

    busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);

    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (cfg_tile_h == '0 || cfg_tile_w == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:
        if (issue && remain_q <= N_W'(2)) state_d = S_DRAIN;
      // Last beat: the only FIFO entry leaves and nothing is left in flight.
      S_DRAIN:
        if (pop && count_q == CNT_W'(1) && inflight == 0) state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_h_q  <= '0;
      img_w_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      tile_w_q <= '0;
      base_q   <= '0;
      pad_q    <= '0;
      pos_q    <= '0;
      remain_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      img_h_q  <= cfg_img_h;
      img_w_q  <= cfg_img_w;
      row_q    <= cfg_tile_row;
      col_q    <= cfg_tile_col;
      tile_w_q <= cfg_tile_w;
      base_q   <= cfg_base_addr;
      pad_q    <= cfg_pad_value;
      pos_q    <= '0;
      remain_q <= {{DIM_W{1'b0}}, cfg_tile_h} * {{DIM_W{1'b0}}, cfg_tile_w};
    end else if (issue) begin
      pos_q    <= two ? pos2 : pos1;
      remain_q <= remain_q - (two ? N_W'(2) : N_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{vld: issue, two: two, pad0: !lane0.inb, pad1: !lane1.inb};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; only pointers and the
  // occupancy count are, and out_data is gated so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tile_reader_2x.sv
// -----------------------------------------------------------------------------
// tb_tile_reader_2x
//   Self-checking bench for tile_reader_2x (RD_LAT=3). A memory model returns
//   addr[7:0] after RD_LAT cycles. Expected beats are computed per tile from
//   the raster/padding rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_tile_reader_2x;

  localparam int RD_LAT = 3;
  localparam int DEPTH  = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_img_h, cfg_img_w, cfg_tile_row, cfg_tile_col, cfg_tile_h, cfg_tile_w;
  logic [31:0] cfg_base_addr;
  logic [7:0]  cfg_pad_value;
  logic        rd_en0, rd_en1;
  logic [31:0] rd_addr0, rd_addr1;
  logic [7:0]  rd_data0, rd_data1;
  logic        out_valid, out_ready, out_two;
  logic [7:0]  out_data0, out_data1;
  logic        busy, done;

  tile_reader_2x #(.DATA_W(8), .ADDR_W(32), .DIM_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w), .cfg_base_addr(cfg_base_addr),
    .cfg_tile_row(cfg_tile_row), .cfg_tile_col(cfg_tile_col),
    .cfg_tile_h(cfg_tile_h), .cfg_tile_w(cfg_tile_w), .cfg_pad_value(cfg_pad_value),
    .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_en1(rd_en1), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_two(out_two),
    .out_data0(out_data0), .out_data1(out_data1),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: data = addr[7:0], RD_LAT cycles after the request.
  logic [31:0] a0p [RD_LAT];
  logic [31:0] a1p [RD_LAT];
  logic        e0p [RD_LAT];
  logic        e1p [RD_LAT];

  always @(posedge clk) begin
    a0p[0] <= rd_addr0; e0p[0] <= rd_en0;
    a1p[0] <= rd_addr1; e1p[0] <= rd_en1;
    for (int i = 1; i < RD_LAT; i++) begin
      a0p[i] <= a0p[i-1]; e0p[i] <= e0p[i-1];
      a1p[i] <= a1p[i-1]; e1p[i] <= e1p[i-1];
    end
  end

  assign rd_data0 = e0p[RD_LAT-1] ? a0p[RD_LAT-1][7:0] : 8'hEE;
  assign rd_data1 = e1p[RD_LAT-1] ? a1p[RD_LAT-1][7:0] : 8'hEE;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct {
    int          img_h, img_w, row, col, th, tw;
    logic [31:0] base;
    logic [7:0]  pad;
  } cfg_t;

  // Log of the first few cycles after start, for issue-pattern checks.
  logic        en0_log [8];
  logic        en1_log [8];
  logic [31:0] a1_log  [8];
  int          max_outstanding;

  function automatic logic [127:0] all_outputs();
    return {rd_en0, rd_addr0, rd_en1, rd_addr1, out_valid, out_two,
            out_data0, out_data1, busy, done};
  endfunction

  // mode: 0 always ready, 1 random ready, 2 stalled 10 cycles then toggling.
  task automatic run_tile(input cfg_t cfg, input int mode, input int restart_at,
                          input int abort_after, input string tag);
    logic [16:0] exp_q [$];
    logic [7:0]  vals  [$];
    logic [16:0] e;
    logic [17:0] prev_vec, cur_vec;
    logic        prev_stall, busy_c1, busy_at_done, any_en, any_valid;
    int          cyc, accepted, issued, last_acc, done_cyc, n;

    // Reference: element k of the tile is (k/tw, k%tw) in raster order.
    n = cfg.th * cfg.tw;
    for (int k = 0; k < n; k++) begin
      int ir, ic;
      logic [31:0] a;
      ir = cfg.row + k / cfg.tw;
      ic = cfg.col + k % cfg.tw;
      if (ir >= 0 && ir < cfg.img_h && ic >= 0 && ic < cfg.img_w) begin
        a = cfg.base + 32'(ir * cfg.img_w + ic);
        vals.push_back(a[7:0]);
      end else begin
        vals.push_back(cfg.pad);
      end
    end
    for (int k = 0; k < n; k += 2)
      exp_q.push_back((k + 1 < n) ? {1'b1, vals[k], vals[k+1]} : {1'b0, vals[k], 8'h00});

    cfg_img_h     = 16'(cfg.img_h);
    cfg_img_w     = 16'(cfg.img_w);
    cfg_tile_row  = 16'(cfg.row);
    cfg_tile_col  = 16'(cfg.col);
    cfg_tile_h    = 16'(cfg.th);
    cfg_tile_w    = 16'(cfg.tw);
    cfg_base_addr = cfg.base;
    cfg_pad_value = cfg.pad;
    out_ready     = 1'b1;
    start         = 1'b1;

    cyc = 0; accepted = 0; issued = 0; last_acc = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_vec = '0; busy_c1 = 1'b0; busy_at_done = 1'b1;
    any_en = 1'b0; any_valid = 1'b0; max_outstanding = 0;

    while (done_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      // Scramble config inputs after start: the DUT must use latched values.
      cfg_base_addr = $urandom;
      cfg_pad_value = 8'($urandom);
      if (cyc == restart_at) begin
        start         = 1'b1;
        cfg_base_addr = cfg.base + 32'h40;
        cfg_tile_w    = 16'(cfg.tw + 1);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc > 10) ? cyc[0] : 1'b0;
      endcase

      if (cyc == 1) busy_c1 = busy;
      if (cyc < 8) begin
        en0_log[cyc] = rd_en0; en1_log[cyc] = rd_en1; a1_log[cyc] = rd_addr1;
      end
      if (rd_en0 || rd_en1) any_en = 1'b1;
      if (out_valid) any_valid = 1'b1;
      if (rd_en0) issued++;
      if (issued - accepted > max_outstanding) max_outstanding = issued - accepted;

      cur_vec = {out_valid, out_two, out_data0, out_data1};
      if (prev_stall) check({tag, "_stable"}, 128'(cur_vec), 128'(prev_vec));
      prev_stall = out_valid && !out_ready;
      prev_vec   = cur_vec;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 128'(cur_vec), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_two"}, 128'(out_two), 128'(e[16]));
          check({tag, "_d0"}, 128'(out_data0), 128'(e[15:8]));
          if (e[16]) check({tag, "_d1"}, 128'(out_data1), 128'(e[7:0]));
        end
        accepted++;
        last_acc = cyc;
        if (!busy) check({tag, "_busy_during"}, 128'(busy), 128'(1));
        if (accepted == abort_after) begin
          rst = 1'b1;
          @(posedge clk); #1;
          check({tag, "_abort_zero"}, all_outputs(), 128'(0));
          rst = 1'b0;
          return;
        end
      end

      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (cyc > 2000) begin
        check({tag, "_timeout"}, 128'(1), 128'(0));
        return;
      end
    end

    check({tag, "_beats_left"}, 128'(exp_q.size()), 128'(0));
    if (n == 0) begin
      check({tag, "_done_lat"}, 128'(done_cyc), 128'(1));
      check({tag, "_no_rd"}, 128'(any_en), 128'(0));
      check({tag, "_no_valid"}, 128'(any_valid), 128'(0));
    end else begin
      check({tag, "_busy_c1"}, 128'(busy_c1), 128'(1));
      check({tag, "_done_lat"}, 128'(done_cyc), 128'(last_acc + 1));
    end
    check({tag, "_busy_at_done"}, 128'(busy_at_done), 128'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    cfg_t c;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_img_h = '0; cfg_img_w = '0; cfg_tile_row = '0; cfg_tile_col = '0;
    cfg_tile_h = '0; cfg_tile_w = '0; cfg_base_addr = '0; cfg_pad_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 3x3 fetch at origin (2,2).
    c = '{img_h: 8, img_w: 8, row: 2, col: 2, th: 3, tw: 3, base: 32'h100, pad: 8'h55};
    run_tile(c, 0, -1, -1, "basic");

    // Halo padding: first pair fully padded, second reads only lane 1.
    c = '{img_h: 8, img_w: 8, row: -1, col: -1, th: 2, tw: 2, base: 32'h100, pad: 8'h80};
    run_tile(c, 0, -1, -1, "pad");
    check("pad_en0_c1", 128'({en0_log[1], en1_log[1]}), 128'(0));
    check("pad_en_c2", 128'({en0_log[2], en1_log[2]}), 128'(2'b01));
    check("pad_addr1_c2", 128'(a1_log[2]), 128'(32'h100));

    // Backpressure: 4x4 fully in-bounds tile, stalled then toggling.
    c = '{img_h: 8, img_w: 8, row: 1, col: 3, th: 4, tw: 4, base: 32'h200, pad: 8'h11};
    run_tile(c, 2, -1, -1, "bp");
    check("bp_max_outstanding", 128'(max_outstanding), 128'(DEPTH));

    // Degenerate tiles.
    c = '{img_h: 8, img_w: 8, row: 0, col: 0, th: 3, tw: 0, base: 32'h100, pad: 8'h22};
    run_tile(c, 0, -1, -1, "w0");
    c = '{img_h: 8, img_w: 8, row: 5, col: 6, th: 1, tw: 1, base: 32'h300, pad: 8'h22};
    run_tile(c, 0, -1, -1, "one");

    // Start while busy is ignored.
    c = '{img_h: 6, img_w: 7, row: 1, col: -2, th: 3, tw: 5, base: 32'h1F0, pad: 8'hA5};
    run_tile(c, 1, 3, -1, "restart");

    // Reset after two beats, then a fresh full tile.
    c = '{img_h: 8, img_w: 8, row: 0, col: 0, th: 4, tw: 3, base: 32'h100, pad: 8'h33};
    run_tile(c, 0, -1, 2, "abort");
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
    run_tile(c, 1, -1, -1, "after_abort");

    // Randomized tiles.
    for (int t = 0; t < 20; t++) begin
      c.img_h = $urandom_range(1, 9);
      c.img_w = $urandom_range(1, 9);
      c.row   = int'($urandom_range(0, 12)) - 3;
      c.col   = int'($urandom_range(0, 12)) - 3;
      c.th    = $urandom_range(1, 5);
      c.tw    = $urandom_range(1, 5);
      c.base  = $urandom;
      c.pad   = 8'($urandom);
      run_tile(c, 1, -1, -1, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_reader_2x.md
Name: tile_reader_2x

Overview:
- Raster-order tile fetcher that feeds the conv datapath two elements per beat. It is the read-side counterpart to the 2-wide tile writer.
- Walks a cfg_tile_h x cfg_tile_w window of an img_h x img_w single-channel feature map stored row-major at cfg_base_addr.
- Issues up to two memory reads per cycle and substitutes cfg_pad_value for positions outside the image (conv halo).
- Emits a valid/ready stream with backpressure, absorbed by an internal skid FIFO sized to the memory latency.

Parameters:
DATA_W, 8, element width
ADDR_W, 32, memory address width
DIM_W, 16, dimension width; tile origin ports are signed DIM_W
RD_LAT, 1, fixed memory read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; latches cfg_*; ignored while busy
cfg_img_h  in  DIM_W  image height
cfg_img_w  in  DIM_W  image width
cfg_base_addr  in  ADDR_W  image base address
cfg_tile_row  in  DIM_W  signed tile origin row (may be negative)
cfg_tile_col  in  DIM_W  signed tile origin column (may be negative)
cfg_tile_h  in  DIM_W  tile height
cfg_tile_w  in  DIM_W  tile width
cfg_pad_value  in  DATA_W  value emitted for out-of-image positions
rd_en0  out  1  read request, lane 0
rd_addr0  out  ADDR_W  read address, lane 0
rd_en1  out  1  read request, lane 1
rd_addr1  out  ADDR_W  read address, lane 1
rd_data0  in  DATA_W  lane 0 data, valid RD_LAT cycles after rd_en0
rd_data1  in  DATA_W  lane 1 data, valid RD_LAT cycles after rd_en1
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_two  out  1  beat carries two elements (out_data1 meaningful)
out_data0  out  DATA_W  element k
out_data1  out  DATA_W  element k+1
busy  out  1  high from the cycle after an accepted start until the cycle done pulses
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every output is 0. FIFO is emptied, counters cleared, state IDLE. rst mid-operation aborts immediately; read data still in flight is discarded.
- State machine:
  - IDLE --start--> ISSUE.
  - ISSUE --last pair issued--> DRAIN.
  - DRAIN --last beat accepted--> DONE.
  - DONE --> IDLE, with done=1 for one cycle.
  - If start arrives with cfg_tile_h==0 or cfg_tile_w==0: go straight to DONE. No reads are issued and no beats are emitted.
- Issue (ISSUE state, when credits allow):
  - Position p=(r,c) goes to lane 0. The next raster position goes to lane 1 only if it exists.
  - The raster counter advances by 2 (or by 1 on the final odd element), wrapping c at tile_w-1 to 0 and incrementing r.
- Credits:
  - FIFO depth is RD_LAT+2 beats.
  - A pair is issued only if FIFO occupancy + in-flight pairs < RD_LAT+2.
  - Result: no beat is ever dropped regardless of out_ready.
- Addressing and padding:
  - ir = tile_row + r and ic = tile_col + c, computed signed at DIM_W+1 bits.
  - In bounds iff 0<=ir<img_h and 0<=ic<img_w.
  - In bounds: rd_en asserted, rd_addr = base + ir*img_w + ic, truncated mod 2^ADDR_W.
  - Out of bounds: rd_en=0, rd_addr=0. A pad flag travels down the RD_LAT-deep pipeline with the pair, and the lane captures cfg_pad_value (latched at start).
- Capture: pipeline stage RD_LAT writes {two, d0, d1} into the FIFO. Each lane selects rd_data or pad per its flag.
- Output: out_valid = FIFO non-empty. Beat pops on out_valid && out_ready. out_data/out_two stay stable while out_valid && !out_ready.
- Beat count is ceil(h*w/2). out_two=0 only on the final beat when h*w is odd.
- Simultaneous push and pop in one cycle is supported; occupancy is unchanged.
- start while busy is ignored, and cfg_* are not re-latched.

Test Plan:
- Basic fetch: 8x8 image, base 0x100, memory returns addr[7:0], RD_LAT=1, origin (2,2), 3x3 tile, out_ready=1 -> 5 beats: (0x12,0x13), (0x14,0x1A), (0x1B,0x1C), (0x22,0x23), then 0x24 with out_two=0. done pulses 1 cycle after the 5th beat is accepted; busy falls the same cycle.
- Padding: origin (-1,-1), 2x2 tile, pad 0x80 -> beats (0x80,0x80), (0x80,0x00). rd_en0 and rd_en1 both low on the first issue cycle; only rd_en1 high on the second (addr 0x100).
- Backpressure: 4x4 tile, RD_LAT=3, out_ready low for 10 cycles then toggling -> at most 5 beats outstanding (FIFO + in flight), all 8 beats arrive in raster order, outputs stable while stalled.
- Degenerate: cfg_tile_w=0 -> no rd_en and no out_valid; done 1 cycle after start. Also 1x1 tile -> single beat, out_two=0.
- Start while busy: a second start mid-tile with a different base is ignored; data still matches the first config.
- Reset mid-operation: rst asserted after 2 beats -> next cycle all outputs are 0. A fresh start then produces a full, correct tile.
